// File: rtl/mem_pkg.sv
// Shared types and constants for the single-ported instruction/data memory arbiter.
package mem_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
  typedef enum logic {CH_IF = 1'b0, CH_D = 1'b1} ch_e;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;
  // Latency counter holds RD_LATENCY-1 down to 0
  localparam int unsigned CNT_W = $clog2(RD_LAT_MAX);

  function automatic int unsigned off_width(int unsigned b_width);
    return $clog2(b_width / 8);
  endfunction

endpackage

// File: rtl/mem_word_ram.sv
// Word memory with byte-enabled synchronous write and a registered read that
// returns zero in cycles without a read.
module mem_word_ram #(
  parameter int unsigned B_WIDTH   = 32,
  parameter int unsigned MEM_DEPTH = 1024,
  localparam int unsigned AW       = $clog2(MEM_DEPTH),
  localparam int unsigned NB       = B_WIDTH / 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_idx,
  input  logic [NB-1:0]      wr_be,
  input  logic [B_WIDTH-1:0] wr_data,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_idx,
  output logic [B_WIDTH-1:0] rd_data
);

  logic [B_WIDTH-1:0] mem [MEM_DEPTH];

  // Contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data <= '0;
    else      rd_data <= rd_en ? mem[rd_idx] : '0;
  end

endmodule

// File: rtl/mem_port_arb.sv
// Arbitrates the fetch and data channels onto one word memory, one transaction
// in flight, with fixed-latency responses and error replies for bad addresses.
module mem_port_arb
  import mem_pkg::*;
#(
  parameter int unsigned B_WIDTH    = 32,
  parameter int unsigned MEM_DEPTH  = 1024,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned RR_MODE    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req,
  input  logic [B_WIDTH-1:0]     if_addr,
  output logic                   if_gnt,
  output logic                   if_rvalid,
  output logic [B_WIDTH-1:0]     if_rdata,
  output logic                   if_err,
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic [B_WIDTH/8-1:0]   d_be,
  input  logic [B_WIDTH-1:0]     d_addr,
  input  logic [B_WIDTH-1:0]     d_wdata,
  output logic                   d_gnt,
  output logic                   d_rvalid,
  output logic [B_WIDTH-1:0]     d_rdata,
  output logic                   d_err
);

  localparam int unsigned OFF_W = off_width(B_WIDTH);
  localparam int unsigned AW    = $clog2(MEM_DEPTH);
  localparam logic [B_WIDTH-1:0] OFF_MASK = B_WIDTH'((64'd1 << OFF_W) - 64'd1);
  localparam logic [B_WIDTH-1:0] DEPTH_W  = B_WIDTH'(MEM_DEPTH);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(RD_LATENCY - 1);
  localparam bit                 LAT1     = (RD_LATENCY == 1);

  function automatic logic addr_bad(input logic [B_WIDTH-1:0] a);
    return ((a & OFF_MASK) != '0) || ((a >> OFF_W) >= DEPTH_W);
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  ch_e                last_q, rsp_ch_q;
  logic               rsp_err_q, rsp_we_q;
  logic [AW-1:0]      rsp_idx_q;
  logic               if_rvalid_q, d_rvalid_q, if_err_q, d_err_q;
  logic               rsp_now, gnt_any, issue;
  ch_e                sel_ch, iss_ch;
  logic [B_WIDTH-1:0] sel_addr, ram_rdata;
  logic               sel_err, sel_we, iss_err, iss_we;
  logic [AW-1:0]      sel_idx, iss_idx;

  assign rsp_now = if_rvalid_q | d_rvalid_q;

  // Arbitration and next state; a grant may overlap the response cycle
  always_comb begin
    if_gnt  = 1'b0;
    d_gnt   = 1'b0;
    state_d = state_q;
    if (rst && (state_q == IDLE || rsp_now)) begin
      if (d_req && (!if_req || RR_MODE == 0 || last_q == CH_IF)) d_gnt = 1'b1;
      else if (if_req)                                           if_gnt = 1'b1;
    end
    case (state_q)
      IDLE:    if (if_gnt || d_gnt) state_d = BUSY;
      BUSY:    if (rsp_now && !(if_gnt || d_gnt)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign gnt_any  = if_gnt | d_gnt;
  assign sel_ch   = d_gnt ? CH_D : CH_IF;
  assign sel_addr = d_gnt ? d_addr : if_addr;
  assign sel_err  = addr_bad(sel_addr);
  assign sel_we   = d_gnt & d_we;
  assign sel_idx  = AW'(sel_addr >> OFF_W);

  // Response is launched at the edge before rvalid; at latency 1 that is the grant edge
  assign issue   = LAT1 ? gnt_any : (state_q == BUSY && cnt_q == CNT_W'(1));
  assign iss_ch  = LAT1 ? sel_ch  : rsp_ch_q;
  assign iss_err = LAT1 ? sel_err : rsp_err_q;
  assign iss_we  = LAT1 ? sel_we  : rsp_we_q;
  assign iss_idx = LAT1 ? sel_idx : rsp_idx_q;

  mem_word_ram #(
    .B_WIDTH   (B_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (d_gnt & d_we & ~sel_err),
    .wr_idx  (sel_idx),
    .wr_be   (d_be),
    .wr_data (d_wdata),
    .rd_en   (issue & ~iss_err & ~iss_we),
    .rd_idx  (iss_idx),
    .rd_data (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Transaction context, latency counter and registered response flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      last_q      <= CH_IF;
      rsp_ch_q    <= CH_IF;
      rsp_err_q   <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_idx_q   <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_err_q    <= 1'b0;
      d_err_q     <= 1'b0;
    end else begin
      if (gnt_any) begin
        cnt_q     <= CNT_LOAD;
        last_q    <= sel_ch;
        rsp_ch_q  <= sel_ch;
        rsp_err_q <= sel_err;
        rsp_we_q  <= sel_we;
        rsp_idx_q <= sel_idx;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if_rvalid_q <= issue && iss_ch == CH_IF;
      d_rvalid_q  <= issue && iss_ch == CH_D;
      if_err_q    <= issue && iss_ch == CH_IF && iss_err;
      d_err_q     <= issue && iss_ch == CH_D && iss_err;
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_err    = if_err_q;
  assign d_err     = d_err_q;
  assign if_rdata  = ram_rdata & {B_WIDTH{if_rvalid_q}};
  assign d_rdata   = ram_rdata & {B_WIDTH{d_rvalid_q}};

endmodule

// File: tb/tb_mem_port_arb.sv
// Four arbiter instances (latency 1..4, alternating arbitration mode) checked
// cycle by cycle against a transaction-level model of the memory and grant timing.
module tb_mem_port_arb;

  localparam int N     = 4;
  localparam int DEPTH = 64;

  logic clk, rst;
  logic [N-1:0]       if_req, if_gnt, if_rvalid, if_err;
  logic [N-1:0]       d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [N-1:0][31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [N-1:0][3:0]  d_be;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_port_arb #(
      .B_WIDTH    (32),
      .MEM_DEPTH  (DEPTH),
      .RD_LATENCY (g + 1),
      .RR_MODE    (g % 2)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req[g]),
      .if_addr   (if_addr[g]),
      .if_gnt    (if_gnt[g]),
      .if_rvalid (if_rvalid[g]),
      .if_rdata  (if_rdata[g]),
      .if_err    (if_err[g]),
      .d_req     (d_req[g]),
      .d_we      (d_we[g]),
      .d_be      (d_be[g]),
      .d_addr    (d_addr[g]),
      .d_wdata   (d_wdata[g]),
      .d_gnt     (d_gnt[g]),
      .d_rvalid  (d_rvalid[g]),
      .d_rdata   (d_rdata[g]),
      .d_err     (d_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: memory image, next-free cycle, pending response per instance
  logic [31:0] mem_m [N][DEPTH];
  int          free_at [N];
  int          rsp_at  [N];
  bit          rsp_d   [N];
  bit          rsp_err [N];
  logic [31:0] rsp_data[N];
  bit          last_d  [N];
  bit          got_if  [N];
  bit          got_d   [N];
  logic [31:0] last_if_rdata[N], last_d_rdata[N];
  logic        last_if_err[N], last_d_err[N];
  logic [3:0]  hist[N];
  int          hn[N], gn[N];
  int          gcyc[N][4];
  int          cyc, checks, errors;

  function automatic logic [31:0] rand_addr();
    int unsigned r = $urandom_range(0, 15);
    if (r == 0) return 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
    if (r == 1) return 32'(4 * DEPTH + 4 * $urandom_range(0, 255));
    if (r == 2) return 32'hFFFF_FFFC;
    return 32'(4 * $urandom_range(0, 7));
  endfunction

  task automatic step();
    logic [69:0] obs, exp;
    logic [31:0] a;
    bit          bad;
    int          idx;
    @(negedge clk);
    for (int g = 0; g < N; g++) begin
      bit can, eig, edg, eir, edr;
      can = rst && (cyc >= free_at[g]);
      edg = can && d_req[g] && (!if_req[g] || (g % 2 == 0) || !last_d[g]);
      eig = can && if_req[g] && !edg;
      eir = rst && rsp_at[g] == cyc && !rsp_d[g];
      edr = rst && rsp_at[g] == cyc && rsp_d[g];
      exp = {eig, eir, eir & rsp_err[g], eir ? rsp_data[g] : 32'h0,
             edg, edr, edr & rsp_err[g], edr ? rsp_data[g] : 32'h0};
      obs = {if_gnt[g], if_rvalid[g], if_err[g], if_rdata[g],
             d_gnt[g], d_rvalid[g], d_err[g], d_rdata[g]};
      checks++;
      assert (obs === exp) else begin
        errors++;
        $error("FAIL port%0d cycle %0d: observed %h expected %h", g, cyc, obs, exp);
      end
      if (if_rvalid[g]) begin last_if_rdata[g] = if_rdata[g]; last_if_err[g] = if_err[g]; end
      if (d_rvalid[g])  begin last_d_rdata[g]  = d_rdata[g];  last_d_err[g]  = d_err[g];  end
      if ((if_gnt[g] || d_gnt[g]) && hn[g] < 4) begin hist[g][hn[g]] = d_gnt[g]; hn[g]++; end
      if (d_gnt[g] && gn[g] < 4) begin gcyc[g][gn[g]] = cyc; gn[g]++; end
      got_if[g] = eig;
      got_d[g]  = edg;
      if (!rst) begin
        rsp_at[g] = -1; free_at[g] = 0; last_d[g] = 1'b0;
      end else if (eig || edg) begin
        a   = edg ? d_addr[g] : if_addr[g];
        bad = (a % 4 != 0) || (a / 4 >= DEPTH);
        rsp_err[g]  = bad;
        rsp_d[g]    = edg;
        rsp_data[g] = 32'h0;
        if (!bad) begin
          idx = int'(a / 4);
          if (edg && d_we[g]) begin
            for (int b = 0; b < 4; b++)
              if (d_be[g][b]) mem_m[g][idx][8*b +: 8] = d_wdata[g][8*b +: 8];
          end else begin
            rsp_data[g] = mem_m[g][idx];
          end
        end
        rsp_at[g]  = cyc + g + 1;
        free_at[g] = cyc + g + 1;
        last_d[g]  = edg;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic d_access(input int g, input bit we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wd);
    d_we[g] = we; d_be[g] = be; d_addr[g] = addr; d_wdata[g] = wd; d_req[g] = 1'b1;
    last_d_rdata[g] = 'x; last_d_err[g] = 1'bx;
    for (int k = 0; k < 16; k++) begin step(); if (got_d[g]) break; end
    checks++;
    assert (got_d[g]) else begin errors++; $error("FAIL d_grant_timeout port%0d: observed no grant, expected grant", g); end
    d_req[g] = 1'b0;
  endtask

  task automatic if_access(input int g, input logic [31:0] addr);
    if_addr[g] = addr; if_req[g] = 1'b1;
    last_if_rdata[g] = 'x; last_if_err[g] = 1'bx;
    for (int k = 0; k < 16; k++) begin step(); if (got_if[g]) break; end
    checks++;
    assert (got_if[g]) else begin errors++; $error("FAIL if_grant_timeout port%0d: observed no grant, expected grant", g); end
    if_req[g] = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst = 1'b0;
    if_req = '0; if_addr = '0; d_req = '0; d_we = '0; d_be = '0; d_addr = '0; d_wdata = '0;
    for (int g = 0; g < N; g++) begin
      free_at[g] = 0; rsp_at[g] = -1; last_d[g] = 1'b0; hn[g] = 0; gn[g] = 0; hist[g] = '0;
    end
    @(posedge clk); #1;
    drain(3);
    rst = 1'b1;
    drain(2);

    // Conflict from reset: both channels held with error addresses (no memory touched)
    for (int g = 0; g < N; g++) begin
      hn[g] = 0; if_req[g] = 1'b1; if_addr[g] = 32'h3;
      d_req[g] = 1'b1; d_we[g] = 1'b0; d_addr[g] = 32'h7;
    end
    for (int k = 0; k < 30; k++) begin
      step();
      if (hn[0] == 4 && hn[1] == 4 && hn[2] == 4 && hn[3] == 4) break;
    end
    if_req = '0; d_req = '0;
    for (int g = 0; g < N; g++) begin
      checks++;
      assert ({hn[g] == 4, hist[g]} === {1'b1, (g % 2 == 0) ? 4'b1111 : 4'b0101}) else begin
        errors++;
        $error("FAIL conflict_order port%0d: observed %0d grants pattern %b, expected 4 grants pattern %b",
               g, hn[g], hist[g], (g % 2 == 0) ? 4'b1111 : 4'b0101);
      end
    end
    drain(5);

    // Preload every word of every instance
    for (int g = 0; g < N; g++)
      for (int w = 0; w < DEPTH; w++) d_access(g, 1'b1, 4'hF, 32'(4 * w), $urandom());
    drain(5);

    // Single read at latency 1
    d_access(0, 1'b1, 4'hF, 32'h14, 32'hDEAD_BEEF);
    if_access(0, 32'h14);
    drain(2);
    checks++;
    assert ({last_if_err[0], last_if_rdata[0]} === {1'b0, 32'hDEAD_BEEF}) else begin
      errors++; $error("FAIL read_word5: observed %h, expected %h", last_if_rdata[0], 32'hDEAD_BEEF);
    end

    // Byte write at latency 3
    d_access(2, 1'b1, 4'hF, 32'h8, 32'h1122_3344);
    d_access(2, 1'b1, 4'b0010, 32'h8, 32'h0000_AB00);
    d_access(2, 1'b0, 4'h0, 32'h8, 32'h0);
    drain(4);
    checks++;
    assert (last_d_rdata[2] === 32'h1122_AB44) else begin
      errors++; $error("FAIL byte_write: observed %h, expected %h", last_d_rdata[2], 32'h1122_AB44);
    end

    // Errors: misaligned and out-of-range, memory untouched
    d_access(0, 1'b0, 4'h0, 32'h3, 32'h0);
    drain(2);
    checks++;
    assert ({last_d_err[0], last_d_rdata[0]} === {1'b1, 32'h0}) else begin
      errors++; $error("FAIL misaligned_err: observed err %b data %h, expected err 1 data 0", last_d_err[0], last_d_rdata[0]);
    end
    if_access(0, 32'(4 * DEPTH));
    drain(2);
    checks++;
    assert ({last_if_err[0], last_if_rdata[0]} === {1'b1, 32'h0}) else begin
      errors++; $error("FAIL range_err: observed err %b data %h, expected err 1 data 0", last_if_err[0], last_if_rdata[0]);
    end
    d_access(0, 1'b1, 4'hF, 32'(4 * DEPTH + 32'h14), 32'h1234_5678);
    d_access(0, 1'b1, 4'hF, 32'h15, 32'h8765_4321);
    if_access(0, 32'h14);
    drain(2);
    checks++;
    assert (last_if_rdata[0] === 32'hDEAD_BEEF) else begin
      errors++; $error("FAIL err_no_write: observed %h, expected %h", last_if_rdata[0], 32'hDEAD_BEEF);
    end

    // Reset two cycles after a write grant at latency 4, request pending across reset
    d_access(3, 1'b1, 4'hF, 32'h24, 32'h5A5A_1234);
    step();
    rst = 1'b0;
    if_req[3] = 1'b1; if_addr[3] = 32'h24;
    drain(2);
    rst = 1'b1;
    last_if_rdata[3] = 'x;
    step();
    if_req[3] = 1'b0;
    drain(5);
    checks++;
    assert (last_if_rdata[3] === 32'h5A5A_1234) else begin
      errors++; $error("FAIL write_survives_reset: observed %h, expected %h", last_if_rdata[3], 32'h5A5A_1234);
    end

    // Back-to-back reads at latency 2
    gn[1] = 0;
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h10;
    for (int k = 0; k < 20; k++) begin step(); if (gn[1] >= 3) break; end
    d_req[1] = 1'b0;
    drain(3);
    checks++;
    assert (gn[1] == 3 && gcyc[1][1] - gcyc[1][0] == 2 && gcyc[1][2] - gcyc[1][1] == 2) else begin
      errors++; $error("FAIL back_to_back: observed %0d grants at %0d/%0d/%0d, expected 3 grants 2 cycles apart",
                       gn[1], gcyc[1][0], gcyc[1][1], gcyc[1][2]);
    end

    // Randomised traffic on all instances
    for (int k = 0; k < 3000; k++) begin
      for (int g = 0; g < N; g++) begin
        if (!if_req[g] && $urandom_range(0, 2) == 0) begin
          if_req[g] = 1'b1; if_addr[g] = rand_addr();
        end
        if (!d_req[g] && $urandom_range(0, 2) == 0) begin
          d_req[g] = 1'b1; d_we[g] = 1'($urandom_range(0, 1)); d_be[g] = 4'($urandom());
          d_addr[g] = rand_addr(); d_wdata[g] = $urandom();
        end
      end
      step();
      for (int g = 0; g < N; g++) begin
        if (got_if[g]) if_req[g] = 1'b0;
        if (got_d[g])  d_req[g]  = 1'b0;
      end
    end
    if_req = '0; d_req = '0;
    drain(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Single-ported word memory shared by the instruction-fetch and data channels of the TRV-32I core, replacing the split instruction/data memory pair. Both channels use a req/gnt/rvalid handshake; one transaction is in flight at a time, read latency is parametrised, and the channels are arbitrated by fixed priority or round-robin. Misaligned and out-of-range accesses complete with an error response instead of touching memory.

## Interface
- B_WIDTH, 32: data word width in bits; a multiple of 8.
- MEM_DEPTH, 1024: memory depth in words.
- RD_LATENCY, 1: cycles from grant to response; legal range 1..4.
- RR_MODE, 0: arbitration mode. 0 = data channel has fixed priority; 1 = round-robin.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  instruction fetch request.
- if_addr  in  B_WIDTH  fetch byte address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch response valid; one-cycle pulse.
- if_rdata  out  B_WIDTH  fetched word.
- if_err  out  1  fetch error; qualified by if_rvalid.
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_be  in  B_WIDTH/8  write byte enables.
- d_addr  in  B_WIDTH  data byte address.
- d_wdata  in  B_WIDTH  write data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  data response valid; one-cycle pulse.
- d_rdata  out  B_WIDTH  read word; 0 for writes and errors.
- d_err  out  1  data error; qualified by d_rvalid.

## Operation
- FSM with two states:
  - IDLE: no transaction in flight.
  - BUSY: a transaction is in flight. A latency counter is loaded at grant and counts down to the response.
- Grant rules:
  - gnt is combinational. It is asserted in a cycle only when the FSM is IDLE, or when it is BUSY and the response is issued in that same cycle.
  - At most one of if_gnt and d_gnt is high in any cycle.
- Arbitration:
  - RR_MODE=0: d_req wins whenever both requests are high.
  - RR_MODE=1: on a conflict, grant the channel not granted last. The last-granted flag resets to "instruction", so data wins the first conflict.
- Requester obligation: hold req and the address/data/control signals stable until gnt is seen. After gnt, the requester may drop or change them.
- Address decode uses word index = addr >> log2(B_WIDTH/8). An access is an error if either:
  - any byte-offset bit of addr is nonzero, or
  - the word index is ≥ MEM_DEPTH.
- Read: the word at the index is captured and returned on rdata with rvalid.
- Write:
  - Only bytes with d_be set are updated, at the end of the grant cycle.
  - d_be = 0 leaves memory unchanged; the write is still acknowledged normally.
  - The response carries rdata = 0 and err = 0.
- Error: no memory read or write occurs. Response carries err = 1 and rdata = 0, with the same latency as a normal access.
- Responses go only to the channel that was granted. The other channel's rvalid, rdata and err stay 0.
- Memory contents are not reset.

## Timing
- Grant in cycle T → rvalid high exactly in cycle T+RD_LATENCY, for exactly one cycle.
- Next grant is possible in cycle T+RD_LATENCY at the earliest. Peak throughput is one access per RD_LATENCY cycles.
- rdata and err are registered and hold their value only while rvalid is high; otherwise they are 0.
- Read-after-write to the same address with back-to-back grants returns the newly written data.
- Reset values: FSM = IDLE, counter = 0, all gnt/rvalid/err = 0, all rdata = 0, round-robin flag = instruction.
- Reset asserted mid-transaction:
  - The in-flight response is dropped; no rvalid is issued after reset is released.
  - A write committed before reset remains in memory.
- While rst is low, no gnt is asserted, even if req is high.

## Structure
- Package mem_pkg holds:
  - the FSM state enum {IDLE, BUSY},
  - the channel enum {CH_IF, CH_D},
  - the RD_LATENCY range constants,
  - a function computing the byte-offset width from B_WIDTH.
- Sub-module mem_word_ram: MEM_DEPTH × B_WIDTH array with a byte-enabled synchronous write and a registered read.
- The top level contains the arbiter, FSM, latency counter, address checks and response steering.

## Test plan
- Single read, RD_LATENCY=1: preload word 5 = 0xDEADBEEF; if_req with if_addr = 0x14 → if_gnt in cycle T, if_rvalid in T+1 with if_rdata = 0xDEADBEEF and if_err = 0.
- Byte write, RD_LATENCY=3: write d_addr = 0x8, d_be = 4'b0010, d_wdata = 0x0000AB00 over an existing word 0x11223344. Then read 0x8 → 0x1122AB44; each rvalid arrives exactly 3 cycles after its gnt.
- Conflict in each mode:
  - RR_MODE=0: if_req and d_req held high together for 4 grants → all 4 grants to data.
  - RR_MODE=1: same stimulus → grants go D, I, D, I.
- Errors:
  - d_addr = 0x3 read → d_rvalid with d_err = 1 and d_rdata = 0.
  - if_addr = 4·MEM_DEPTH → if_err = 1.
  - In both cases memory is unchanged.
- Reset during BUSY with RD_LATENCY=4: drop rst two cycles after grant → no rvalid appears; all outputs are 0; a grant occurs in the first cycle after reset is released when a request is pending.
- Back-to-back with RD_LATENCY=2: d_req held high for 3 reads → grants in cycles T, T+2, T+4 and rvalids in cycles T+2, T+4, T+6.
